// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_stage
// Purpose  : Writeback stage behind the ALU/multiplier. Buffers up to two
//            results {r1, n, z, c, v, rd, setflags} in a small FIFO and retires
//            them in order to the register-file write port. Entries that set
//            flags commit n/z/c/v to the architectural status register on
//            retirement.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            in_valid/in_ready   - ALU result handshake
//            r1, n, z, c, v, rd  - result payload
//            setflags            - commit flags on retirement
//            flush               - drop all buffered entries
//            rf_busy             - register file cannot take a write
//            rf_we/waddr/wdata   - register-file write port (head entry)
//            flag_n/z/c/v        - architectural status register
//            flags_pending       - a buffered entry will set flags
//            count               - occupancy 0..2
// Revision : 1.0 - initial release
// ============================================================================
module alu_wb_stage #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   r1,
    input  logic          n,
    input  logic          z,
    input  logic          c,
    input  logic          v,
    input  logic [AW-1:0] rd,
    input  logic          setflags,
    input  logic          flush,
    input  logic          rf_busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_v,
    output logic          flags_pending,
    output logic [1:0]    count
);

    localparam logic [1:0] C_FULL = 2'(DEPTH);

    // Entry storage (intentionally not reset; validity is tracked by count).
    logic [31:0]   r_data  [0:1];
    logic [3:0]    r_nzcv  [0:1];
    logic [AW-1:0] r_rd    [0:1];
    logic          r_sf    [0:1];

    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_count;
    logic [3:0]    r_flags;

    logic          w_accept;
    logic          w_retire;

    // in_ready depends only on registered occupancy, so a retire in a full
    // cycle cannot open a slot until the next cycle (no bypass).
    assign in_ready = (r_count != C_FULL);
    assign rf_we    = (r_count != 2'd0) && !rf_busy;
    assign rf_waddr = r_rd[r_rd_ptr];
    assign rf_wdata = r_data[r_rd_ptr];
    assign count    = r_count;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_retire = rf_we;

    // With two slots, the head is valid when count >= 1 and the other slot
    // is valid only when the FIFO is full.
    assign flags_pending = ((r_count != 2'd0) && r_sf[r_rd_ptr]) ||
                           ((r_count == C_FULL) && r_sf[~r_rd_ptr]);

    assign flag_n = r_flags[3];
    assign flag_z = r_flags[2];
    assign flag_c = r_flags[1];
    assign flag_v = r_flags[0];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[r_wr_ptr] <= r1;
            r_nzcv[r_wr_ptr] <= {n, z, c, v};
            r_rd[r_wr_ptr]   <= rd;
            r_sf[r_wr_ptr]   <= setflags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_flags  <= 4'b0000;
        end else begin
            // A retire completes even in a flush cycle, including its flags.
            if (w_retire && r_sf[r_rd_ptr]) begin
                r_flags <= r_nzcv[r_rd_ptr];
            end
            if (flush) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_accept) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_retire) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_accept, w_retire})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wb_stage
// Purpose  : Self-checking bench for alu_wb_stage. A queue-based model of the
//            writeback buffer predicts every output each cycle; directed
//            sequences are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wb_stage;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   r1;
    logic          n, z, c, v;
    logic [AW-1:0] rd;
    logic          setflags;
    logic          flush;
    logic          rf_busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          flags_pending;
    logic [1:0]    count;

    always #5 clk = ~clk;

    alu_wb_stage #(.DEPTH(2), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .r1            (r1),
        .n             (n),
        .z             (z),
        .c             (c),
        .v             (v),
        .rd            (rd),
        .setflags      (setflags),
        .flush         (flush),
        .rf_busy       (rf_busy),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .flags_pending (flags_pending),
        .count         (count)
    );

    typedef struct {
        logic [31:0]   d;
        logic [3:0]    f;      // {n, z, c, v}
        logic [AW-1:0] r;
        logic          sf;
    } ent_t;

    ent_t       m_q[$];
    logic [3:0] m_flags;
    logic       m_known = 1'b0;   // model state defined once a reset was applied

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, advance
    // the model and the clock. Called just after a falling edge.
    task automatic step(input logic vld, input logic [31:0] d, input logic [3:0] f,
                        input logic [AW-1:0] r, input logic sf, input logic fl,
                        input logic busy, input logic rst);
        logic exp_we;
        logic exp_pend;
        logic acc;
        ent_t e;
        reset = rst; in_valid = vld; r1 = d;
        {n, z, c, v} = f; rd = r; setflags = sf; flush = fl; rf_busy = busy;
        #1;
        exp_we   = (m_q.size() != 0) && !busy;
        exp_pend = 1'b0;
        foreach (m_q[i]) exp_pend = exp_pend | m_q[i].sf;
        if (m_known) begin
            check("count",         32'(count),         32'(m_q.size()));
            check("in_ready",      32'(in_ready),      32'(m_q.size() < 2));
            check("rf_we",         32'(rf_we),         32'(exp_we));
            check("flags",         32'({flag_n, flag_z, flag_c, flag_v}), 32'(m_flags));
            check("flags_pending", 32'(flags_pending), 32'(exp_pend));
            if (m_q.size() != 0) begin
                check("rf_waddr", 32'(rf_waddr), 32'(m_q[0].r));
                check("rf_wdata", rf_wdata,      m_q[0].d);
            end
        end
        acc = vld && (m_q.size() < 2) && !fl;
        if (rst) begin
            m_q.delete();
            m_flags = 4'b0000;
            m_known = 1'b1;
        end else if (m_known) begin
            if (exp_we) begin
                e = m_q.pop_front();
                if (e.sf) m_flags = e.f;
            end
            if (fl) begin
                m_q.delete();
            end else if (acc) begin
                e.d = d; e.f = f; e.r = r; e.sf = sf;
                m_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b0, 32'h0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Single flagged result: r1=0, z=1, rd=3
        step(1'b1, 32'h0, 4'b0100, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Back-to-back stream 1..4
        for (int i = 1; i <= 4; i++)
            step(1'b1, 32'(i), 4'h0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Backpressure and full: 0xC held by source until accepted
        step(1'b1, 32'hA, 4'h0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hB, 4'h0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hC, 4'h0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hC, 4'h0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hC, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);  // retire A, C refused
        step(1'b1, 32'hC, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);  // retire B, accept C
        idle(3);

        // Flag selectivity: n without setflags, then v/c with setflags
        step(1'b1, 32'h11, 4'b1000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 4'b0011, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Flush with count=2 and a simultaneous in_valid
        step(1'b1, 32'h31, 4'b1111, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h32, 4'b0000, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h33, 4'b0101, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Reset mid-stream with flags = 1111 and count = 2
        step(1'b1, 32'h44, 4'b1111, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 32'h45, 4'b0000, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h46, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h47, 4'b0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), AW'($urandom),
                 1'($urandom), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
